// File: rtl/alu_pkg.sv
// Shared definitions for controllers that sequence operations onto the 32-bit ALU:
// opcode encodings, the legality test and the sequencing state enum.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0110;
    localparam logic [3:0] OP_SBC = 4'b0111;
    localparam logic [3:0] OP_LSL = 4'b1000;
    localparam logic [3:0] OP_LSR = 4'b1001;
    localparam logic [3:0] OP_USR = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    // Sequencing states of a shared-ALU controller.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_e;

    // True for every opcode the ALU implements; 0101 and 1100..1111 are holes.
    function automatic logic opcode_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADC,
            OP_SBC, OP_LSL, OP_LSR, OP_USR, OP_NOT: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or above the start
// pointer, wrapping to the lowest set request when none lies above it.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] req_hi;
    logic [NUM_REQ-1:0] pick_src;

    // Mask of positions at or above the start pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i >= int'(ptr_i));
        end
    end

    assign req_hi   = req_i & hi_mask;
    assign pick_src = (|req_hi) ? req_hi : req_i;

    // Lowest set bit of the chosen vector wins (downward scan, last hit kept).
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational 32-bit ALU among NUM_REQ requesters.
// One operation at a time: grant, drive the ALU for a cycle, offer the
// registered result on a valid/ready channel tagged with the owner's index.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    // Kept at least one bit wide so a single-requester build stays legal.
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    input  logic [4*NUM_REQ-1:0]  req_op,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_opcode,
    input  logic [31:0]           alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    alu_state_e         state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    owner_q;
    logic [31:0]        alu_a_q;
    logic [31:0]        alu_b_q;
    logic [3:0]         alu_op_q;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [31:0]        rsp_data_q;
    logic               rsp_err_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_idx;
    logic [31:0]        win_a;
    logic [31:0]        win_b;
    logic [3:0]         win_op;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Grant is only offered while idle and out of reset.
    assign req_ready = (rst_n && state_q == IDLE) ? pick_gnt : '0;

    // Pointer moves just past the winner; a single requester keeps it at 0.
    assign rr_ptr_d = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // One-hot mux of the winner's operands and opcode.
    always_comb begin
        win_a  = '0;
        win_b  = '0;
        win_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_a  = req_a[32*i +: 32];
                win_b  = req_b[32*i +: 32];
                win_op = req_op[4*i +: 4];
            end
        end
    end

    // Sequencer: accept, drive ALU for one cycle, hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all state moves together on the edge regardless of statement order.
            unique case (state_q)
                IDLE: begin
                    if (|pick_gnt) begin
                        alu_a_q  <= win_a;
                        alu_b_q  <= win_b;
                        alu_op_q <= win_op;
                        owner_q  <= pick_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_result;
                    rsp_id_q    <= owner_q;
                    rsp_err_q   <= ~opcode_legal(alu_op_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: plays the external ALU, runs directed scenarios and
// a randomized phase, and compares every cycle against a transaction model.
module tb_alu_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic [4*NUM_REQ-1:0]  req_op = '0;
    logic [31:0]           alu_a;
    logic [31:0]           alu_b;
    logic [3:0]            alu_opcode;
    logic [31:0]           alu_result;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_err;

    int checks   = 0;
    int failures = 0;

    int grant_log[$];
    logic [31:0] rsp_log[$];

    always #5 clk = ~clk;

    alu_share_ctrl #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    // Behavioural stand-in for the external ALU; holes in the opcode map give 0.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd6:    return a + b + 32'd1;
            4'd7:    return a - b - 32'd1;
            4'd8:    return a << b[4:0];
            4'd9:    return a >> b[4:0];
            4'd10:   return 32'($signed(a) >>> b[4:0]);
            4'd11:   return ~a;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return (op == 4'd5) || (op >= 4'd12);
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_opcode);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_age: 0 nothing in flight, 1 accepted at the previous edge, 2 response on offer.
    int                 m_age = 0;
    int                 m_ptr = 0;
    logic [31:0]        m_a = '0, m_b = '0, m_data = '0, m_pend_data = '0;
    logic [3:0]         m_op = '0;
    logic [ID_W-1:0]    m_id = '0, m_pend_id = '0;
    logic               m_err = 1'b0, m_pend_err = 1'b0;
    logic [NUM_REQ-1:0] prev_valid = '0, prev_rdy = '0;
    logic [32*NUM_REQ-1:0] prev_a = '0, prev_b = '0;
    logic [4*NUM_REQ-1:0]  prev_op = '0;

    task automatic monitor_step();
        logic [NUM_REQ-1:0] exp_rdy;
        int w;
        if (!rst_n) begin
            m_age = 0; m_ptr = 0; m_a = '0; m_b = '0; m_op = '0;
            m_data = '0; m_id = '0; m_err = 1'b0; prev_valid = '0; prev_rdy = '0;
            return;
        end
        exp_rdy = '0;
        w = -1;
        if (m_age == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_REQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;

        check("req_ready", req_ready, exp_rdy);
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_opcode", alu_opcode, m_op);
        check("rsp_valid", rsp_valid, m_age == 2);
        check("rsp_data", rsp_data, m_data);
        check("rsp_id", rsp_id, m_id);
        check("rsp_err", rsp_err, m_err);

        // Requester rule: a waiting request keeps its operands stable.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prev_valid[i] && !prev_rdy[i] && req_valid[i]) begin
                assert (req_a[32*i +: 32] == prev_a[32*i +: 32] &&
                        req_b[32*i +: 32] == prev_b[32*i +: 32] &&
                        req_op[4*i +: 4] == prev_op[4*i +: 4])
                else $error("requester %0d changed operands while waiting", i);
            end
        end
        prev_valid = req_valid; prev_rdy = req_ready;
        prev_a = req_a; prev_b = req_b; prev_op = req_op;

        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
        if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);

        if (w >= 0) begin
            m_age       = 1;
            m_a         = req_a[32*w +: 32];
            m_b         = req_b[32*w +: 32];
            m_op        = req_op[4*w +: 4];
            m_pend_data = alu_model(m_a, m_b, m_op);
            m_pend_err  = op_illegal(m_op);
            m_pend_id   = ID_W'(w);
            m_ptr       = (w + 1) % NUM_REQ;
        end else if (m_age == 1) begin
            m_age  = 2;
            m_data = m_pend_data;
            m_id   = m_pend_id;
            m_err  = m_pend_err;
        end else if (m_age == 2 && rsp_ready) begin
            m_age = 0;
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver helpers ----------------
    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input int stall, input bit busy_others,
                         input logic [31:0] exp_d, input logic exp_err);
        int n;
        @(posedge clk); #1;
        rsp_ready = (stall == 0);
        req_valid[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_op[4*id +: 4]  = op;
        n = 0;
        @(negedge clk); #1;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept_wait", n < 20, 1'b1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (busy_others)
            for (int k = 0; k < NUM_REQ; k++) if (k != id) req_valid[k] = 1'b1;
        @(negedge clk);
        check("exec_no_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        check("rsp_latency", rsp_valid, 1'b1);
        check("op_data", rsp_data, exp_d);
        check("op_id", rsp_id, 64'(id));
        check("op_err", rsp_err, exp_err);
        for (int s = 1; s <= stall; s++) begin
            @(posedge clk); #1;
            if (s == stall) rsp_ready = 1'b1;
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_data", rsp_data, exp_d);
            check("bp_id", rsp_id, 64'(id));
            check("bp_no_ready", req_ready, 4'b0000);
        end
        @(posedge clk); #1;
        if (busy_others) req_valid = '0;
        @(negedge clk);
        check("rsp_done", rsp_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        int rbase;
        int exp_order[5];
        logic [NUM_REQ-1:0] hs;

        apply_reset();
        @(negedge clk);
        check("reset_req_ready", req_ready, 4'b0000);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_alu_a", alu_a, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);

        // Single add on requester 0.
        do_op(0, 32'd5, 32'd3, 4'b0000, 0, 1'b0, 32'd8, 1'b0);

        // Round-robin with everyone requesting continuously.
        apply_reset();
        base  = grant_log.size();
        rbase = rsp_log.size();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = 32'hFFFF0000;
            req_b[32*i +: 32] = 32'h0F0F0F0F;
            req_op[4*i +: 4]  = 4'b0010;
        end
        req_valid = '1;
        n = 0;
        while (grant_log.size() < base + 5 && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        check("rr_wait", n < 60, 1'b1);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_rsp_count", rsp_log.size() >= rbase + 5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (base + k < grant_log.size())
                check("rr_grant_order", 64'(grant_log[base + k]), 64'(exp_order[k]));
            if (rbase + k < rsp_log.size())
                check("rr_rsp_data", rsp_log[rbase + k], 32'h0F0F0000);
        end

        // Back-pressure on requester 2 while others wait.
        do_op(2, 32'd10, 32'd3, 4'b0001, 5, 1'b1, 32'd7, 1'b0);

        // Illegal opcode, then a NOT.
        do_op(1, 32'h12345678, 32'h9, 4'b1100, 0, 1'b0, 32'd0, 1'b1);
        do_op(1, 32'd0, 32'h55, 4'b1011, 0, 1'b0, 32'hFFFFFFFF, 1'b0);

        // Pointer wrap: grant 2 leaves the pointer at 3, then 1 and 3 compete.
        do_op(2, 32'd7, 32'd9, 4'b0011, 0, 1'b0, 32'h0000000F, 1'b0);
        base = grant_log.size();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_a[32*1 +: 32] = 32'd1;   req_b[32*1 +: 32] = 32'd2; req_op[4*1 +: 4] = 4'b0000;
        req_a[32*3 +: 32] = 32'd100; req_b[32*3 +: 32] = 32'd1; req_op[4*3 +: 4] = 4'b0001;
        req_valid = 4'b1010;
        n = 0;
        while (grant_log.size() < base + 2 && n < 40) begin
            @(negedge clk); #1;
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~hs;
            n++;
        end
        check("wrap_wait", n < 40, 1'b1);
        req_valid = '0;
        repeat (5) @(posedge clk);
        if (grant_log.size() >= base + 2) begin
            check("wrap_first", 64'(grant_log[base]), 64'd3);
            check("wrap_second", 64'(grant_log[base + 1]), 64'd1);
        end else begin
            check("wrap_grants", 64'(grant_log.size() - base), 64'd2);
        end

        // Reset in the middle of an operation.
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_a[32*3 +: 32] = 32'hDEADBEEF; req_b[32*3 +: 32] = 32'h1; req_op[4*3 +: 4] = 4'b0100;
        req_valid[3] = 1'b1;
        n = 0;
        @(negedge clk); #1;
        while (!req_ready[3] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_accept_wait", n < 20, 1'b1);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_opcode", alu_opcode, 4'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_id", rsp_id, 2'd0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_req_ready", req_ready, 4'b0000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk); #1;
        check("rst_first_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);

        // Randomized traffic with random back-pressure and opcodes.
        repeat (1500) begin
            @(negedge clk); #1;
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[32*i +: 32] = $urandom();
                    req_b[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                                                   : $urandom();
                    req_op[4*i +: 4] = 4'($urandom_range(0, 15));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("drain_idle", rsp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
